// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and state encoding for the TX and RX sides
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_TICK_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with one-entry holding register, optional parity and 2 stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int TICK_PER_BIT = UART_TICK_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_Clock,
    input  logic       i_reset,
    input  logic       sample_tick,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done
);

    localparam int              CW       = $clog2(TICK_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_PER_BIT - 1);
    localparam logic [2:0]      IDX_LAST = 3'(UART_DATA_BITS - 1);
    localparam logic            PAR_INV  = (PARITY_ODD != 0);

    uart_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic          stop_cnt, stop_cnt_n;
    logic [7:0]    hold, hold_n;
    logic          hold_full, hold_full_n;
    logic [7:0]    shift, shift_n;
    logic          serial, serial_n;
    logic          active, active_n;
    logic          done, done_n;
    logic          bit_end;
    logic          load;
    logic          accept;

    assign accept      = i_TX_DV && !hold_full;
    assign o_TX_Ready  = !hold_full;
    assign o_TX_Serial = serial;
    assign o_TX_Active = active;
    assign o_TX_Done   = done;

    always_ff @(posedge i_Clock) begin
        if (i_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            serial    <= 1'b1;
            active    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            stop_cnt  <= stop_cnt_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            shift     <= shift_n;
            serial    <= serial_n;
            active    <= active_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        stop_cnt_n = stop_cnt;
        shift_n    = shift;
        serial_n   = serial;
        active_n   = active;
        done_n     = 1'b0;
        load       = 1'b0;
        bit_end    = 1'b0;

        // Bit timer runs only while a frame is on the line
        if (state != IDLE && sample_tick) begin
            if (cnt == CNT_LAST) begin
                cnt_n   = '0;
                bit_end = 1'b1;
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end

        case (state)
            IDLE: begin
                serial_n = 1'b1;
                active_n = 1'b0;
                if (sample_tick && hold_full) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    serial_n  = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx != IDX_LAST) begin
                        bit_idx_n = bit_idx + 3'd1;
                        serial_n  = shift[bit_idx + 3'd1];
                    end else if (PARITY_EN != 0) begin
                        state_n  = PARITY;
                        serial_n = (^shift) ^ PAR_INV;
                    end else begin
                        state_n    = STOP;
                        stop_cnt_n = 1'b0;
                        serial_n   = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                    serial_n   = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (STOP_BITS == 2 && !stop_cnt) begin
                        stop_cnt_n = 1'b1;
                    end else begin
                        done_n = 1'b1;
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_n  = IDLE;
                            active_n = 1'b0;
                            serial_n = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                serial_n = 1'b1;
                active_n = 1'b0;
            end
        endcase

        // Reload from the holding register starts the next start bit on this edge
        if (load) begin
            state_n  = START;
            cnt_n    = '0;
            shift_n  = hold;
            serial_n = 1'b0;
            active_n = 1'b1;
        end

        hold_n      = hold;
        hold_full_n = hold_full;
        if (load) begin
            hold_full_n = 1'b0;
        end
        if (accept) begin
            hold_n      = i_TX_Byte;
            hold_full_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across three parameter sets
module tb_uart_tx;

    localparam int TPB [3] = '{16, 16, 3};
    localparam int PE  [3] = '{0, 1, 1};
    localparam int PO  [3] = '{0, 0, 1};
    localparam int SB  [3] = '{1, 2, 1};
    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       dv  [3];
    logic [7:0] byt [3];
    logic       rdy [3];
    logic       ser [3];
    logic       act [3];
    logic       dn  [3];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int nframes  [3];
    longint last_done [3];
    longint prev_done [3];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    always #5 clk = ~clk;

    uart_tx #(.TICK_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .i_Clock(clk), .i_reset(rst), .sample_tick(tick), .i_TX_DV(dv[0]), .i_TX_Byte(byt[0]),
        .o_TX_Ready(rdy[0]), .o_TX_Serial(ser[0]), .o_TX_Active(act[0]), .o_TX_Done(dn[0]));
    uart_tx #(.TICK_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .i_Clock(clk), .i_reset(rst), .sample_tick(tick), .i_TX_DV(dv[1]), .i_TX_Byte(byt[1]),
        .o_TX_Ready(rdy[1]), .o_TX_Serial(ser[1]), .o_TX_Active(act[1]), .o_TX_Done(dn[1]));
    uart_tx #(.TICK_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .i_Clock(clk), .i_reset(rst), .sample_tick(tick), .i_TX_DV(dv[2]), .i_TX_Byte(byt[2]),
        .o_TX_Ready(rdy[2]), .o_TX_Serial(ser[2]), .o_TX_Active(act[2]), .o_TX_Done(dn[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void qpush(input int k, input logic [7:0] b);
        case (k)
            0: q0.push_back(b);
            1: q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic logic [7:0] qpop(input int k);
        if (qsize(k) == 0) return 8'h00;
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Tick strobe: one clock high every TICK_DIV clocks
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            tick = (cyc % TICK_DIV == 0);
        end
    end

    // Frame checker: expected frame = start 0, D0..D7, optional parity, stop 1s, each TPB*TICK_DIV clocks
    task automatic mon(input int k);
        int L, nb, errs;
        logic [7:0]  d;
        logic [11:0] bits;
        logic        par;
        bit          ab;
        L  = TPB[k] * TICK_DIV;
        nb = 1 + 8 + PE[k] + SB[k];
        @(negedge clk);
        forever begin
            if (ser[k] === 1'b0 && rst === 1'b0) begin
                chk($sformatf("unexpected_frame_%0d", k), (qsize(k) > 0), 1);
                d    = qpop(k);
                par  = (PE[k] != 0) ? ((^d) ^ PO[k][0]) : 1'b1;
                bits = {3'b111, par, d, 1'b0};
                errs = 0;
                ab   = 1'b0;
                for (int b = 0; b < nb && !ab; b++) begin
                    for (int c = 0; c < L && !ab; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (ser[k] !== bits[b] || act[k] !== 1'b1) errs++;
                        if ((b != 0 || c != 0) && dn[k] !== 1'b0) errs++;
                        if (rst === 1'b1) ab = 1'b1;
                    end
                end
                @(negedge clk);
                if (!ab) begin
                    chk($sformatf("frame_bits_%0d_%02h", k, d), errs, 0);
                    chk($sformatf("done_pulse_%0d", k), dn[k], 1'b1);
                    prev_done[k] = last_done[k];
                    last_done[k] = $time;
                    nframes[k]++;
                end
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);

    task automatic wait_rdy(input int k, input int lim);
        int n = 0;
        while (rdy[k] !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ready_timeout_%0d", k), rdy[k], 1'b1);
    endtask

    task automatic wait_low(input int k, input int lim);
        int n = 0;
        while (ser[k] !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("start_timeout_%0d", k), ser[k], 1'b0);
    endtask

    task automatic send(input int k, input logic [7:0] b);
        wait_rdy(k, 3000);
        dv[k]  = 1'b1;
        byt[k] = b;
        @(posedge clk);
        qpush(k, b);
        @(negedge clk);
        dv[k]  = 1'b0;
        byt[k] = $urandom;
    endtask

    task automatic idle_clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int f0, errs, n;
        logic [7:0] rb;
        int rk;
        for (int k = 0; k < 3; k++) begin
            dv[k] = 1'b0; byt[k] = 8'h00; nframes[k] = 0; last_done[k] = 0; prev_done[k] = 0;
        end
        rst = 1'b1;
        idle_clocks(3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_serial_%0d", k), ser[k], 1'b1);
            chk($sformatf("reset_ready_%0d", k), rdy[k], 1'b1);
            chk($sformatf("reset_active_%0d", k), act[k], 1'b0);
            chk($sformatf("reset_done_%0d", k), dn[k], 1'b0);
        end
        rst = 1'b0;
        idle_clocks(5);

        // Plain 8N1 frame of 0xA5
        send(0, 8'hA5);
        chk("ready_low_after_accept", rdy[0], 1'b0);
        wait_low(0, 200);
        chk("ready_after_load", rdy[0], 1'b1);
        chk("active_at_start", act[0], 1'b1);

        // Back-to-back 0x00 then 0xFF with the second accepted during DATA
        wait_rdy(0, 2000);
        while (act[0] === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        f0 = nframes[0];
        send(0, 8'h00);
        wait_low(0, 200);
        idle_clocks(3 * 64);
        send(0, 8'hFF);
        chk("ready_low_while_full", rdy[0], 1'b0);
        wait_rdy(0, 1000);
        chk("reload_start_bit", ser[0], 1'b0);
        chk("reload_active", act[0], 1'b1);
        n = 0;
        while (nframes[0] < f0 + 2 && n < 2000) begin @(negedge clk); n++; end
        chk("two_frames_done", nframes[0], f0 + 2);
        chk("done_spacing", 32'(last_done[0] - prev_done[0]), 32'd6400);

        // Parity variants and two stop bits
        send(1, 8'hA5);
        send(1, 8'h07);
        send(1, 8'h3C);
        send(2, 8'hA5);
        send(2, 8'h07);

        // Byte offered while holding register is full must be dropped
        wait_rdy(0, 2000);
        send(0, 8'h3C);
        wait_low(0, 200);
        send(0, 8'hC3);
        chk("drop_precondition", rdy[0], 1'b0);
        dv[0] = 1'b1; byt[0] = 8'h11;
        @(negedge clk);
        dv[0] = 1'b0;
        chk("drop_ready_still_low", rdy[0], 1'b0);

        // Reset during DATA bit 3 with a byte pending
        n = 0;
        while (!(act[1] === 1'b0 && act[2] === 1'b0 && qsize(1) == 0 && qsize(2) == 0) && n < 10000) begin
            @(negedge clk); n++;
        end
        wait_rdy(0, 3000);
        idle_clocks(1000);
        send(0, 8'h96);
        wait_low(0, 200);
        send(0, 8'h99);
        idle_clocks(4 * 64 + 20);
        chk("pre_reset_active", act[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        chk("abort_serial", ser[0], 1'b1);
        chk("abort_active", act[0], 1'b0);
        chk("abort_ready", rdy[0], 1'b1);
        chk("abort_done", dn[0], 1'b0);
        errs = 0;
        repeat (300) begin
            @(negedge clk);
            if (ser[0] !== 1'b1 || dn[0] !== 1'b0 || act[0] !== 1'b0) errs++;
        end
        chk("abort_quiet_line", errs, 0);
        send(0, 8'h5A);

        // Randomised traffic across all three instances
        for (int i = 0; i < 24; i++) begin
            rk = $urandom_range(0, 2);
            rb = 8'($urandom);
            send(rk, rb);
            idle_clocks($urandom_range(0, 300));
        end

        n = 0;
        while (!(qsize(0) == 0 && qsize(1) == 0 && qsize(2) == 0 &&
                 act[0] === 1'b0 && act[1] === 1'b0 && act[2] === 1'b0) && n < 40000) begin
            @(negedge clk); n++;
        end
        idle_clocks(10);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("queue_drained_%0d", k), qsize(k), 0);
            chk($sformatf("final_idle_%0d", k), act[k], 1'b0);
            chk($sformatf("final_line_%0d", k), ser[k], 1'b1);
            chk($sformatf("final_ready_%0d", k), rdy[k], 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter; the transmit-side companion to the existing 8-bit UART receiver. Sends 8N1 frames by default, with optional parity and 2 stop bits. Data is sent LSB first, and bit timing comes from the same shared oversampling sample_tick that drives the receiver. A one-entry holding register allows back-to-back frames with no idle gap between them.

Parameters:
TICK_PER_BIT, 16, sample_tick pulses per bit; must be >=2 and must match the RX instance
PARITY_EN, 0, 1 inserts a parity bit after D7
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; legal values are 1 or 2

Ports:
i_Clock  in  1  system clock; all logic is on the rising edge
i_reset  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle oversampling strobe, shared with the RX
i_TX_DV  in  1  byte-valid strobe; accepted only when o_TX_Ready=1
i_TX_Byte  in  8  byte to send; sampled in the cycle it is accepted
o_TX_Ready  out  1  holding register empty; a byte can be accepted
o_TX_Serial  out  1  serial line output; idle level is 1
o_TX_Active  out  1  high from start-bit entry through the end of the final stop bit
o_TX_Done  out  1  one-cycle pulse when a frame's final stop bit completes

Behaviour:
- Reset: synchronous and active-high. On the reset edge: o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0, state=IDLE, and the bit counter, bit index, holding register and shift register all clear. A reset mid-frame aborts the frame: the line is high on the next edge and any pending byte is discarded.
- Accept: when i_TX_DV && o_TX_Ready, latch i_TX_Byte into the holding register; o_TX_Ready goes 0 on the next cycle.
  - i_TX_DV while o_TX_Ready=0 is ignored, with no side effects.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Line is 1.
  - Leaves only on a cycle where sample_tick=1 and the holding register is full.
  - On that edge: enter START, drive the line to 0, move the holding register to the shift register, set o_TX_Ready=1 and o_TX_Active=1.
  - Aligning to a tick makes every bit exactly TICK_PER_BIT tick periods long.
- Bit timing (all non-IDLE states):
  - The counter is 0 on state entry and advances only on sample_tick.
  - On a tick with counter==TICK_PER_BIT-1, the counter resets to 0 and the current bit ends; otherwise the counter increments.
  - Counter width is $clog2(TICK_PER_BIT).
- START: drives 0; at bit end, go to DATA with bit_index=0.
- DATA:
  - Drives shift[bit_index], so D0 is sent first.
  - At bit end: if bit_index<7, increment it; otherwise go to PARITY when PARITY_EN=1, else to STOP.
- PARITY: drives ^data XOR PARITY_ODD; at bit end, go to STOP.
- STOP:
  - Drives 1 for STOP_BITS bit periods; an internal stop counter tracks the second stop bit.
  - At the final stop-bit end, pulse o_TX_Done=1 for exactly one cycle, then:
    - If the holding register is full, go directly to START on the same edge (line to 0, reload shift register, o_TX_Ready=1, o_TX_Active stays 1). The next start bit begins with no gap.
    - Otherwise go to IDLE with o_TX_Active=0.
- Simultaneous events:
  - An accept on the same cycle as the IDLE→START or STOP→START transfer is legal: the new byte lands in the freshly freed holding register.
  - sample_tick does not affect acceptance.
- The line output is registered, with no combinational path from inputs.
- Latency:
  - Accept to start-bit edge: at most 1 tick period plus 1 clock when idle.
  - Frame length: (1+8+PARITY_EN+STOP_BITS)*TICK_PER_BIT ticks.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants (IDLE/START/DATA/PARITY/STOP);
  - UART_DATA_BITS=8;
  - UART_TICK_PER_BIT default=16.
  The RX adopts the same package.
- No sub-module: the sample_tick generator is the existing shared baud-tick block, external to uart_tx.

Test Plan:
1. TICK_PER_BIT=16, tick every 4 clocks, send 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,1 with each bit 64 clocks; one o_TX_Done pulse; loopback into the RX gives o_RX_DV with o_RX_Data=0xA5.
2. Send 0x00 then 0xFF, the second byte accepted while the first is in DATA -> o_TX_Ready low until the reload; no idle gap between the stop of 0x00 and the start of 0xFF; two o_TX_Done pulses 640 clocks apart; RX receives 0x00 then 0xFF.
3. PARITY_EN=1: 0xA5 with PARITY_ODD=0 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; 0x07 even -> parity bit 1. Frame is 11 bits.
4. STOP_BITS=2, send 0x3C -> line high for 128 clocks after D7; o_TX_Done fires at the end of the second stop bit.
5. Pulse i_TX_DV with 0x11 while o_TX_Ready=0 and the holding register is full -> byte dropped; only the previously queued bytes appear on the line.
6. Assert i_reset during DATA bit 3 -> on the next edge o_TX_Serial=1, o_TX_Active=0, o_TX_Ready=1, no o_TX_Done; a subsequent send of 0x5A transmits correctly.
